// File: rtl/down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// down_counter_ctrl
//
// Prescaled down-counter with one-shot and auto-reload modes, pause/abort
// control, and a terminal-count pulse.
//
// A start request is accepted only in IDLE and only with a non-zero load
// value. The load value, prescale divider and reload mode are captured on
// that edge. While running, the count decrements once every prescale+1
// cycles. When the count is 1 at a tick, one of two things happens:
//   - In one-shot mode the count becomes 0, tc pulses and the block passes
//     through DONE for one cycle.
//   - In auto-reload mode the count restarts from the captured load value
//     and tc pulses.
//
// Parameters
//   WIDTH      counter width
//   PSC_W      prescaler width
//
// Ports
//   clk        clock, all logic on rising edge
//   rst        synchronous reset, active low
//   start      launch request (IDLE only)
//   load_val   initial / reload count, captured on accepted start
//   prescale   divider, one decrement per prescale+1 cycles
//   reload_en  1 = periodic auto-reload, 0 = one-shot
//   pause      level; freezes counting while high
//   abort      cancels an active run (RUN or PAUSE)
//   count      current count (registered)
//   busy       high in RUN or PAUSE (registered)
//   tc         one-cycle terminal-count pulse (registered)
//   done       high exactly while in DONE (registered)
//   err        one-cycle pulse on a rejected start (registered)
// ---------------------------------------------------------------------------
module down_counter_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PSC_W-1:0] prescale,
    input  logic             reload_en,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PAUSE,
        ST_DONE
    } state_t;

    state_t           state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic [PSC_W-1:0] psc_q,     psc_d;
    logic [PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic             mode_q,    mode_d;
    logic             busy_q,    busy_d;
    logic             tc_q,      tc_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    // Set when this edge is a counting edge.
    logic             advance;

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        psc_d     = psc_q;
        psc_cnt_d = psc_cnt_q;
        mode_d    = mode_q;
        tc_d      = 1'b0;
        err_d     = 1'b0;
        advance   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (load_val != '0) begin
                        count_d   = load_val;
                        reload_d  = load_val;
                        psc_d     = prescale;
                        mode_d    = reload_en;
                        psc_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (abort) begin
                    count_d   = '0;
                    psc_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    advance = 1'b1;
                end
            end

            ST_PAUSE: begin
                if (abort) begin
                    count_d   = '0;
                    psc_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else if (!pause) begin
                    // The release edge counts as a normal RUN edge. As a
                    // result, a pause lasting N edges delays the run by
                    // exactly N cycles.
                    state_d = ST_RUN;
                    advance = 1'b1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (psc_cnt_q == psc_q) begin
                psc_cnt_d = '0;
                if (count_q > WIDTH'(1)) begin
                    count_d = count_q - WIDTH'(1);
                end else if (mode_q) begin
                    count_d = reload_q;
                    tc_d    = 1'b1;
                end else begin
                    // A count of 0 is also treated as terminal here, so
                    // the count can never wrap below zero.
                    count_d = '0;
                    tc_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end else begin
                psc_cnt_d = psc_cnt_q + PSC_W'(1);
            end
        end

        // Status flags are registered copies of the next state, so they
        // line up with state_q on the cycle after the edge.
        busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d = (state_d == ST_DONE);
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            psc_q     <= '0;
            psc_cnt_q <= '0;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            psc_q     <= psc_d;
            psc_cnt_q <= psc_cnt_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            tc_q      <= tc_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign tc    = tc_q;
    assign done  = done_q;
    assign err   = err_q;

endmodule

// File: tb/tb_down_counter_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for down_counter_ctrl.
//
// A driver applies stimulus at the falling edge and pushes the expected
// post-edge outputs into a scoreboard queue. A monitor pops one entry after
// every rising edge and compares it with the DUT outputs.
//
// The reference model tracks a coarse phase (idle / active / done) and the
// number of counting edges since the run started. The count is derived from
// that edge total by arithmetic.
// ---------------------------------------------------------------------------
module tb_down_counter_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned PW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  load_val;
    logic [PW-1:0] prescale;
    logic          reload_en;
    logic          pause;
    logic          abort;
    logic [W-1:0]  count;
    logic          busy;
    logic          tc;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    down_counter_ctrl #(
        .WIDTH (W),
        .PSC_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .load_val  (load_val),
        .prescale  (prescale),
        .reload_en (reload_en),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .busy      (busy),
        .tc        (tc),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         busy;
        logic         tc;
        logic         done;
        logic         err;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycle  = 0;

    // Reference model state: phase 0 = idle, 1 = active, 2 = done.
    int m_phase = 0;
    int m_L     = 0;
    int m_P     = 0;
    int m_e     = 0;
    int m_cnt   = 0;
    bit m_R     = 1'b0;

    // Drive one cycle of inputs, predict the outputs after the coming rising
    // edge, then wait for the falling edge.
    task automatic step(input bit r, input bit s, input int lv, input int pv,
                        input bit re, input bit pz, input bit ab);
        exp_t x;
        int   per;
        int   pos;
        rst       = r;
        start     = s;
        load_val  = W'(lv);
        prescale  = PW'(pv);
        reload_en = re;
        pause     = pz;
        abort     = ab;
        x = '0;
        if (!r) begin
            m_phase = 0;
            m_cnt   = 0;
        end else begin
            case (m_phase)
                0: begin
                    if (s) begin
                        if (lv != 0) begin
                            m_phase = 1;
                            m_L     = lv;
                            m_P     = pv;
                            m_R     = re;
                            m_e     = 0;
                            m_cnt   = lv;
                        end else begin
                            x.err = 1'b1;
                        end
                    end
                end
                1: begin
                    if (ab) begin
                        m_phase = 0;
                        m_cnt   = 0;
                    end else if (!pz) begin
                        per = m_L * (m_P + 1);
                        m_e = m_e + 1;
                        if (m_R) begin
                            pos   = m_e % per;
                            m_cnt = m_L - pos / (m_P + 1);
                            x.tc  = (pos == 0);
                        end else begin
                            m_cnt = m_L - m_e / (m_P + 1);
                            if (m_e == per) begin
                                x.tc    = 1'b1;
                                m_phase = 2;
                            end
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
        x.count = W'(m_cnt);
        x.busy  = (m_phase == 1);
        x.done  = (m_phase == 2);
        sb.push_back(x);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: one comparison after every rising edge.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            checks++;
            a = {count, busy, tc, done, err};
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty cycle=%0d: got no expectation, required one per edge", cycle);
            end else begin
                e = sb.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle=%0d: got count=%0d busy=%b tc=%b done=%b err=%b, required count=%0d busy=%b tc=%b done=%b err=%b",
                             cycle, a.count, a.busy, a.tc, a.done, a.err,
                             e.count, e.busy, e.tc, e.done, e.err);
                end
            end
        end
    end

    initial begin
        bit r, s, re, pz, ab;
        int lv, pv;

        // Reset, then a one-shot start on the first edge with rst high.
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 9, 0, 0, 0, 0);
        step(1, 1, 3, 0, 0, 0, 0);
        idle(5);
        // pause/abort in IDLE have no effect.
        step(1, 0, 0, 0, 0, 1, 1);

        // Prescaled one-shot.
        step(1, 1, 2, 2, 0, 0, 0);
        idle(8);

        // Auto-reload; a start with load 0 mid-run is ignored (no err).
        step(1, 1, 2, 0, 1, 0, 0);
        idle(3);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(4);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Pause for 4 cycles at count 3.
        step(1, 1, 5, 0, 0, 0, 0);
        idle(2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 1, 0);
        idle(6);

        // Abort during PAUSE, then a rejected start.
        step(1, 1, 4, 1, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 0, 0);
        idle(2);

        // Reset mid-run at count 4, then restart with 7.
        step(1, 1, 6, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 7, 0, 0, 0, 0);
        idle(9);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 99) >= 2);
            s  = ($urandom_range(0, 99) < 30);
            lv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255))
                                             : int'($urandom_range(0, 6));
            pv = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, 15));
            re = 1'($urandom_range(0, 1));
            pz = ($urandom_range(0, 99) < 15);
            ab = ($urandom_range(0, 99) < 2);
            step(r, s, lv, pv, re, pz, ab);
        end

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
